// File: rtl/phase_update_unit.sv
// -----------------------------------------------------------------------------
// phase_update_unit
//
// Purpose:
//   Measures the phase offset between the neighbour oscillator (nin) and the
//   own oscillator (nout). The offset is the number of tick strobes between
//   their rising edges. The unit then produces an updated phase: phi_out is
//   moved towards the neighbour by that offset.
//
// Parameters:
//   PW  - phase / difference width in bits (2..8)
//   TMO - ticks after the first edge before a missing second edge aborts
//
// Ports:
//   clk     in   system clock, rising edge
//   re      in   asynchronous active-low reset
//   tick    in   sample enable; edges are detected and counters advance on it
//   nin     in   neighbour square wave (asynchronous to clk)
//   nout    in   own square wave (asynchronous to clk)
//   phi_out in   current own phase, sampled only in the UPDATE state
//   phase   out  updated phase (registered)
//   diff    out  last measured phase-difference magnitude
//   lead    out  1 = nin rose first, 0 = nout rose first or both together
//   valid   out  one-clk pulse when phase/diff/lead update
//   timeout out  one-clk pulse when a measurement is aborted
//
// Build option:
//   PHASE_SAT_EN - when defined, the phase add/subtract saturates at
//                  2**PW-1 and 0. When undefined, it wraps modulo 2**PW.
// -----------------------------------------------------------------------------
module phase_update_unit #(
  parameter int PW  = 4,
  parameter int TMO = 2**PW
) (
  input  logic          clk,
  input  logic          re,
  input  logic          tick,
  input  logic          nin,
  input  logic          nout,
  input  logic [PW-1:0] phi_out,
  output logic [PW-1:0] phase,
  output logic [PW-1:0] diff,
  output logic          lead,
  output logic          valid,
  output logic          timeout
);

  // The counter only has to hold 0..TMO-1. The extended width also holds
  // cnt+1 and the largest diff value, so the saturation compare is exact.
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int XW = ((CW + 1) > PW) ? (CW + 1) : PW;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  localparam logic [XW-1:0] DIFF_MAX = XW'((2**PW) - 1);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, UPDATE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [PW-1:0] meas_reg;
  logic          lead_reg;

  // Bit 0 carries nin, bit 1 carries nout.
  logic [1:0] pin_vec;
  logic [1:0] sync_vec;
  logic [1:0] hist_reg;
  logic [1:0] rise;

  assign pin_vec = {nout, nin};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk or negedge re) begin
        if (!re) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= pin_vec[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_vec[gi] = s2_reg;
    end
  endgenerate

  // The edge history advances only on ticks. A rising edge is therefore
  // "high now, low at the previous tick", not "low at the previous clk".
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      hist_reg <= 2'b00;
    end else if (tick) begin
      hist_reg <= sync_vec;
    end
  end

  assign rise = sync_vec & ~hist_reg;

  // Edge of the signal that did not start the measurement.
  logic other_rise;
  assign other_rise = lead_reg ? rise[1] : rise[0];

  // diff = cnt + 1, clamped to the largest PW-bit value.
  logic [XW-1:0] cnt_ext;
  logic [PW-1:0] meas_next;
  assign cnt_ext   = XW'(cnt_reg) + XW'(1);
  assign meas_next = (cnt_ext > DIFF_MAX) ? {PW{1'b1}} : cnt_ext[PW-1:0];

  logic [PW-1:0] phase_next;
`ifdef PHASE_SAT_EN
  logic [PW:0] sum_ext;
  logic [PW:0] sub_ext;
  assign sum_ext = {1'b0, phi_out} + {1'b0, meas_reg};
  assign sub_ext = {1'b0, phi_out} - {1'b0, meas_reg};
  always_comb begin
    phase_next = phi_out;
    if (lead_reg) begin
      // A carry out means the sum passed the top of the range.
      phase_next = sum_ext[PW] ? {PW{1'b1}} : sum_ext[PW-1:0];
    end else begin
      // A borrow means the difference went below zero.
      phase_next = sub_ext[PW] ? {PW{1'b0}} : sub_ext[PW-1:0];
    end
  end
`else
  assign phase_next = lead_reg ? (phi_out + meas_reg) : (phi_out - meas_reg);
`endif

  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      meas_reg  <= '0;
      lead_reg  <= 1'b0;
      phase     <= '0;
      diff      <= '0;
      lead      <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tick) begin
            state_reg <= ARM;
          end
        end

        ARM: begin
          if (tick) begin
            if (rise[0] && rise[1]) begin
              // Coincident edges: zero offset, skip counting.
              meas_reg  <= '0;
              lead_reg  <= 1'b0;
              state_reg <= UPDATE;
            end else if (rise[0]) begin
              lead_reg  <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= COUNT;
            end else if (rise[1]) begin
              lead_reg  <= 1'b0;
              cnt_reg   <= '0;
              state_reg <= COUNT;
            end
          end
        end

        COUNT: begin
          if (tick) begin
            // The second edge wins over the abort when both land on the
            // same tick. Repeat edges of the leading signal are ignored.
            if (other_rise) begin
              meas_reg  <= meas_next;
              state_reg <= UPDATE;
            end else if (cnt_reg == CNT_LAST) begin
              timeout   <= 1'b1;
              state_reg <= ARM;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end

        UPDATE: begin
          // Exactly one clk, regardless of tick.
          phase     <= phase_next;
          diff      <= meas_reg;
          lead      <= lead_reg;
          valid     <= 1'b1;
          state_reg <= ARM;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
